// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential HI/LO multiply/divide unit for a MIPS-style CPU.
// One radix-2 iteration per cycle (shift-add multiply, restoring divide)
// over 32 cycles, plus a final cycle for sign fixup and the HI/LO write.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   issue strobe; op selects MULT/MULTU/DIV/DIVU/MTHI/MTLO (6-7 ignored)
//   op      3-bit operation code
//   rs, rt  operands (rs is also the MTHI/MTLO data)
//   rd_req  CPU is executing MFHI/MFLO this cycle
//   hi, lo  architectural HI/LO registers
//   busy    multiply/divide in progress
//   stall   pipeline hold request: busy & (rd_req | start)
//   done    one-cycle pulse after an arithmetic result is written
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        rd_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  localparam logic [5:0] LAST_CNT = 6'd32;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic        last, step, issue, mt_wr, signed_op;
  logic        is_div, neg_q, neg_r, div0;
  logic [31:0] acc_hi, acc_lo, opb;
  logic signed [31:0] rs_s, rt_s;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [31:0] res_hi, res_lo;

  function automatic logic [31:0] mag32(input logic signed [31:0] x, input logic sgn);
    mag32 = (sgn && x[31]) ? 32'(-x) : 32'(x);
  endfunction

  function automatic logic [31:0] fix32(input logic [31:0] v, input logic neg);
    fix32 = neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] fix64(input logic [63:0] v, input logic neg);
    fix64 = neg ? (~v + 64'd1) : v;
  endfunction

  assign rs_s  = rs;
  assign rt_s  = rt;
  assign busy  = (state == RUN);
  assign stall = busy & (rd_req | start);

  // Issue is also accepted on the finishing edge so ops can run back to back.
  always_comb begin
    last      = (state == RUN) && (cnt == LAST_CNT);
    step      = (state == RUN) && (cnt != LAST_CNT);
    issue     = start && !op[2] && ((state == IDLE) || last);
    mt_wr     = start && (state == IDLE) && (op == 3'd4 || op == 3'd5);
    signed_op = !op[0];
    state_nx  = state;
    case (state)
      IDLE:    if (issue) state_nx = RUN;
      RUN:     if (last && !issue) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Per-iteration datapath and final sign fixup.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
    div_sh  = {acc_hi, acc_lo[31]};
    div_ge  = (div_sh >= {1'b0, opb});
    // The true difference is below the divisor, so 32 bits hold it exactly.
    div_rem = div_sh[31:0] - opb;
    res_hi  = acc_hi;
    res_lo  = acc_lo;
    if (is_div) begin
      // Divide by zero yields an all-ones quotient; the restoring loop
      // already leaves |rs| as remainder, and the fixup restores rs.
      res_lo = div0 ? 32'hFFFF_FFFF : fix32(acc_lo, neg_q);
      res_hi = fix32(acc_hi, neg_r);
    end else begin
      {res_hi, res_lo} = fix64({acc_hi, acc_lo}, neg_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (issue)     cnt <= '0;
      else if (step) cnt <= cnt + 6'd1;
      else if (last) cnt <= '0;
      if (last) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (mt_wr) begin
        if (op[0]) lo <= rs;
        else       hi <= rs;
      end
    end
  end

  // Issue edge: latch magnitudes and result signs / iteration edges.
  always_ff @(posedge clk) begin
    if (issue) begin
      is_div <= op[1];
      neg_q  <= signed_op && (rs[31] ^ rt[31]);
      neg_r  <= signed_op && rs[31];
      div0   <= (rt == 32'd0);
      acc_hi <= '0;
      if (op[1]) begin
        acc_lo <= mag32(rs_s, signed_op);
        opb    <= mag32(rt_s, signed_op);
      end else begin
        acc_lo <= mag32(rt_s, signed_op);
        opb    <= mag32(rs_s, signed_op);
      end
    end else if (step) begin
      if (is_div) begin
        acc_hi <= div_ge ? div_rem : div_sh[31:0];
        acc_lo <= {acc_lo[30:0], div_ge};
      end else begin
        acc_hi <= mul_sum[32:1];
        acc_lo <= {mul_sum[0], acc_lo[31:1]};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, rd_req;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic [31:0] hi, lo;
  logic        busy, stall, done;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs(rs), .rt(rt),
    .rd_req(rd_req), .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on 64-bit integers.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = 32'd0;
    el = 32'd0;
    case (o)
      3'd0: begin p = sa * sb; {eh, el} = p; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; {eh, el} = p; end
      3'd2: begin
        if (b == 32'd0) begin el = 32'hFFFF_FFFF; eh = a; end
        else begin
          q = sa / sb; r = sa % sb;
          p = q; el = p[31:0];
          p = r; eh = p[31:0];
        end
      end
      3'd3: begin
        if (b == 32'd0) begin el = 32'hFFFF_FFFF; eh = a; end
        else begin el = a / b; eh = a % b; end
      end
      default: begin eh = m_hi; el = m_lo; end
    endcase
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; op = 3'd0; rs = 32'd5; rt = 32'd7; rd_req = 1'b1;
    tick; tick;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_errors++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo); end
    start = 1'b0; rd_req = 1'b0;
    tick;
    rst = 1'b0;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall_after: got %b want 0", stall); end
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] eh, el;
    model(o, a, b, eh, el);
    op = o; rs = a; rt = b; start = 1'b1;
    tick;
    start = 1'b0; rs = $urandom; rt = $urandom;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL %s busy_after_issue: got %b want 1", name, busy); end
    for (int k = 1; k <= 32; k++) begin
      tick;
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        n_errors++;
        $display("FAIL %s run_cycle%0d: busy=%b done=%b hi=%h lo=%h want 1 0 %h %h", name, k, busy, done, hi, lo, m_hi, m_lo);
      end
    end
    tick;
    n_checks++; if (busy !== 1'b0 || done !== 1'b1) begin n_errors++; $display("FAIL %s finish: busy=%b done=%b want 0 1", name, busy, done); end
    n_checks++; if (hi !== eh) begin n_errors++; $display("FAIL %s hi: got %h want %h", name, hi, eh); end
    n_checks++; if (lo !== el) begin n_errors++; $display("FAIL %s lo: got %h want %h", name, lo, el); end
    m_hi = eh; m_lo = el;
    tick;
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL %s done_once: got %b want 0", name, done); end
  endtask

  task automatic test_vectors;
    test_op(3'd0, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    test_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    test_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    test_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    test_op(3'd3, 32'd100, 32'd0, "divu_by0");
    test_op(3'd2, 32'hFFFF_FFFB, 32'd0, "div_neg_by0");
    test_op(3'd2, 32'd7, 32'hFFFF_FFFE, "div_7_neg2");
    test_op(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i % 5 == 4) b = 32'd0;
      else if (i % 3 == 2) b = 32'($urandom_range(1, 300));
      test_op(o, a, b, "random");
    end
  endtask

  task automatic test_stall;
    logic [31:0] a, b, eh, el;
    a = $urandom; b = 32'($urandom_range(1, 1000));
    model(3'd3, a, b, eh, el);
    op = 3'd3; rs = a; rt = b; start = 1'b1; rd_req = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      n_checks++;
      if (stall !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
        n_errors++;
        $display("FAIL stall_hold cycle%0d: stall=%b hi=%h lo=%h want 1 %h %h", k, stall, hi, lo, m_hi, m_lo);
      end
      if (k == 4) begin op = 3'd0; rs = 32'd12345; rt = 32'd678; start = 1'b1; end
      tick;
      if (k == 4) start = 1'b0;
    end
    n_checks++; if (stall !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL stall_release: stall=%b busy=%b want 0 0", stall, busy); end
    n_checks++; if (hi !== eh || lo !== el) begin n_errors++; $display("FAIL stall_result: got %h/%h want %h/%h", hi, lo, eh, el); end
    m_hi = eh; m_lo = el;
    rd_req = 1'b0;
    tick;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL stall_ignored_start: busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a1, b1, a2, b2, eh1, el1, eh2, el2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = 32'($urandom_range(1, 5000));
    model(3'd1, a1, b1, eh1, el1);
    model(3'd2, a2, b2, eh2, el2);
    op = 3'd1; rs = a1; rt = b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 32; k++) tick;
    op = 3'd2; rs = a2; rt = b2; start = 1'b1;
    tick;
    start = 1'b0;
    n_checks++; if (done !== 1'b1 || busy !== 1'b1) begin n_errors++; $display("FAIL b2b_accept: done=%b busy=%b want 1 1", done, busy); end
    n_checks++; if (hi !== eh1 || lo !== el1) begin n_errors++; $display("FAIL b2b_first: got %h/%h want %h/%h", hi, lo, eh1, el1); end
    for (int k = 1; k <= 32; k++) tick;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_second_busy: got %b want 1", busy); end
    tick;
    n_checks++; if (busy !== 1'b0 || done !== 1'b1) begin n_errors++; $display("FAIL b2b_second_finish: busy=%b done=%b want 0 1", busy, done); end
    n_checks++; if (hi !== eh2 || lo !== el2) begin n_errors++; $display("FAIL b2b_second: got %h/%h want %h/%h", hi, lo, eh2, el2); end
    m_hi = eh2; m_lo = el2;
    tick;
  endtask

  task automatic test_abort_and_mt;
    logic [31:0] d;
    op = 3'd0; rs = $urandom; rt = $urandom; start = 1'b1;
    tick;
    start = 1'b0; rd_req = 1'b1;
    for (int k = 1; k <= 9; k++) tick;
    rst = 1'b1;
    tick;
    n_checks++; if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL abort_ctrl: busy=%b stall=%b done=%b want 0 0 0", busy, stall, done); end
    n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_errors++; $display("FAIL abort_hilo: got %h/%h want 0/0", hi, lo); end
    rst = 1'b0; rd_req = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    for (int k = 0; k < 40; k++) begin
      tick;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        n_errors++;
        $display("FAIL abort_quiet cycle%0d: done=%b busy=%b hi=%h lo=%h", k, done, busy, hi, lo);
      end
    end
    op = 3'd5; rs = 32'h0000_1234; start = 1'b1;
    tick;
    start = 1'b0;
    n_checks++; if (lo !== 32'h1234 || hi !== 32'd0 || busy !== 1'b0) begin n_errors++; $display("FAIL mtlo: lo=%h hi=%h busy=%b want 1234 0 0", lo, hi, busy); end
    m_lo = 32'h1234;
    tick;
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL mtlo_done: got %b want 0", done); end
    d = $urandom;
    op = 3'd4; rs = d; start = 1'b1;
    tick;
    start = 1'b0;
    n_checks++; if (hi !== d || lo !== m_lo || busy !== 1'b0) begin n_errors++; $display("FAIL mthi: hi=%h lo=%h busy=%b want %h %h 0", hi, lo, busy, d, m_lo); end
    m_hi = d;
    for (int r = 6; r <= 7; r++) begin
      op = 3'(r); rs = $urandom; rt = $urandom; start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        n_errors++;
        $display("FAIL reserved_op%0d: busy=%b done=%b hi=%h lo=%h want 0 0 %h %h", r, busy, done, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; rs = 32'd0; rt = 32'd0; rd_req = 1'b0;
    test_reset;
    test_vectors;
    test_random;
    test_stall;
    test_back_to_back;
    test_abort_and_mt;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
